rc4_phase_sequencer: RTL and testbench

//  Top-level sequencer/arbiter for the RC4 key-search datapath. Owns the single-port 256x8 S RAM and grants
//  it to one of three phase engines (FILL: s[i]=i, KSA: swap loop, PRGA: decrypt+check) in strict order.

---
 rtl/rc4_pkg.sv | 47 ++++
 rtl/phase_watchdog.sv | 33 +++
 rtl/rc4_phase_sequencer.sv | 171 +++++++++++++++++
 tb/tb_rc4_phase_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and constants for the RC4 key-search sequencer
package rc4_pkg;

    localparam int N_PHASE = 3;
    localparam int S_DEPTH = 256;

    typedef enum logic [1:0] {
        PH_FILL = 2'd0,
        PH_KSA  = 2'd1,
        PH_PRGA = 2'd2
    } phase_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR,
        ST_FILL_GO,
        ST_FILL_WAIT,
        ST_KSA_GO,
        ST_KSA_WAIT,
        ST_PRGA_GO,
        ST_PRGA_WAIT,
        ST_NEXT_KEY,
        ST_FOUND,
        ST_EXHAUSTED,
        ST_ERROR
    } seq_state_t;

    // vld=0 means no engine owns the S RAM
    typedef struct packed {
        logic   vld;
        phase_e ph;
    } grant_t;

    // An engine owns the RAM from its GO cycle through the end of its WAIT
    function automatic grant_t grant_of(input seq_state_t s);
        grant_t g;
        g = '{vld: 1'b0, ph: PH_FILL};
        case (s)
            ST_FILL_GO, ST_FILL_WAIT: g = '{vld: 1'b1, ph: PH_FILL};
            ST_KSA_GO,  ST_KSA_WAIT:  g = '{vld: 1'b1, ph: PH_KSA};
            ST_PRGA_GO, ST_PRGA_WAIT: g = '{vld: 1'b1, ph: PH_PRGA};
            default:                  g = '{vld: 1'b0, ph: PH_FILL};
        endcase
        return g;
    endfunction

endpackage

// File: rtl/phase_watchdog.sv
// rtl/phase_watchdog.sv - per-phase hang detector for the RC4 sequencer
module phase_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,      // system clock
    input  logic reset_n,  // async active-low reset
    input  logic clear,    // restart the count (phase GO cycle)
    input  logic enable,   // count this cycle (phase WAIT cycle)
    output logic expired   // phase has waited too long
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_plus;

    assign cnt_plus = cnt + CW'(1);

    // Expiry fires on the step that takes the count to TIMEOUT-1, so the
    // sequencer leaves WAIT on that same edge: TIMEOUT cycles after GO.
    assign expired = enable && (cnt_plus == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt_plus;
        end
    end

endmodule

// File: rtl/rc4_phase_sequencer.sv
// rtl/rc4_phase_sequencer.sv - S RAM arbiter and phase sequencer for RC4 key search
module rc4_phase_sequencer
    import rc4_pkg::*;
#(
    parameter int KEY_W    = 24,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int KEY_STEP = 1,
    parameter int TIMEOUT  = 4096
) (
    input  logic                        clk,         // system clock
    input  logic                        reset_n,     // async active-low reset
    input  logic                        start,       // begin search (idle/terminal only)
    input  logic                        abort,       // sync abort from any state
    input  logic [KEY_W-1:0]            key_start,   // first key tried
    input  logic [KEY_W-1:0]            key_end,     // last key tried, inclusive
    output logic [N_PHASE-1:0]          ph_start,    // start pulse [0]=FILL [1]=KSA [2]=PRGA
    input  logic [N_PHASE-1:0]          ph_done,     // completion pulses
    input  logic [N_PHASE-1:0]          ph_wren,     // per-engine RAM write enable
    input  logic [N_PHASE*ADDR_W-1:0]   ph_addr,     // per-engine RAM address, phase 0 in LSBs
    input  logic [N_PHASE*DATA_W-1:0]   ph_data,     // per-engine RAM write data
    input  logic                        prga_ok,     // qualified by ph_done[2]
    output logic                        reset_task,  // one-cycle clear to all engines
    output logic                        mem_wren,    // S RAM write enable
    output logic [ADDR_W-1:0]           mem_addr,    // S RAM address
    output logic [DATA_W-1:0]           mem_data,    // S RAM write data
    output logic [KEY_W-1:0]            secret_key,  // key under test
    output logic                        busy,
    output logic                        found,
    output logic                        exhausted,
    output logic                        error
);

    seq_state_t       state_q, state_d;
    grant_t           grant_q;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W:0]   key_sum;
    logic [KEY_W-1:0] key_inc;
    logic             key_last;
    logic             abort_q;
    logic             wd_clear, wd_enable, wd_expired;

    // Saturating step: the carry out of the sum selects all-ones
    assign key_sum  = {1'b0, key_q} + (KEY_W + 1)'(KEY_STEP);
    assign key_inc  = key_sum[KEY_W] ? {KEY_W{1'b1}} : key_sum[KEY_W-1:0];
    assign key_last = (key_q >= key_end);

    assign wd_clear  = (state_q == ST_FILL_GO) || (state_q == ST_KSA_GO) || (state_q == ST_PRGA_GO);
    assign wd_enable = (state_q == ST_FILL_WAIT) || (state_q == ST_KSA_WAIT) || (state_q == ST_PRGA_WAIT);

    phase_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Done is tested before the watchdog so a completion on the expiry cycle wins
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_ERROR: begin
                if (start) state_d = ST_CLR;
            end
            ST_CLR:     state_d = ST_FILL_GO;
            ST_FILL_GO: state_d = ST_FILL_WAIT;
            ST_FILL_WAIT: begin
                if (ph_done[PH_FILL])  state_d = ST_KSA_GO;
                else if (wd_expired)   state_d = ST_ERROR;
            end
            ST_KSA_GO: state_d = ST_KSA_WAIT;
            ST_KSA_WAIT: begin
                if (ph_done[PH_KSA])   state_d = ST_PRGA_GO;
                else if (wd_expired)   state_d = ST_ERROR;
            end
            ST_PRGA_GO: state_d = ST_PRGA_WAIT;
            ST_PRGA_WAIT: begin
                if (ph_done[PH_PRGA])  state_d = prga_ok ? ST_FOUND : ST_NEXT_KEY;
                else if (wd_expired)   state_d = ST_ERROR;
            end
            ST_NEXT_KEY: state_d = key_last ? ST_EXHAUSTED : ST_CLR;
            default:     state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    // Grant is registered from the next state so the RAM mux has no decode
    // in front of it and the engine owns the bus on its GO cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q <= '{vld: 1'b0, ph: PH_FILL};
            key_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            grant_q <= grant_of(state_d);
            abort_q <= abort;
            if (state_d == ST_CLR) begin
                key_q <= (state_q == ST_NEXT_KEY) ? key_inc : key_start;
            end
        end
    end

    always_comb begin
        ph_start   = '0;
        reset_task = abort_q;
        busy       = 1'b1;
        found      = 1'b0;
        exhausted  = 1'b0;
        error      = 1'b0;
        case (state_q)
            ST_IDLE:      busy = 1'b0;
            ST_CLR:       reset_task = 1'b1;
            ST_FILL_GO:   ph_start[PH_FILL] = 1'b1;
            ST_KSA_GO:    ph_start[PH_KSA]  = 1'b1;
            ST_PRGA_GO:   ph_start[PH_PRGA] = 1'b1;
            ST_FOUND: begin
                busy  = 1'b0;
                found = 1'b1;
            end
            ST_EXHAUSTED: begin
                busy      = 1'b0;
                exhausted = 1'b1;
            end
            ST_ERROR: begin
                busy  = 1'b0;
                error = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_wren = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (grant_q.vld) begin
            case (grant_q.ph)
                PH_FILL: begin
                    mem_wren = ph_wren[0];
                    mem_addr = ph_addr[0*ADDR_W +: ADDR_W];
                    mem_data = ph_data[0*DATA_W +: DATA_W];
                end
                PH_KSA: begin
                    mem_wren = ph_wren[1];
                    mem_addr = ph_addr[1*ADDR_W +: ADDR_W];
                    mem_data = ph_data[1*DATA_W +: DATA_W];
                end
                PH_PRGA: begin
                    mem_wren = ph_wren[2];
                    mem_addr = ph_addr[2*ADDR_W +: ADDR_W];
                    mem_data = ph_data[2*DATA_W +: DATA_W];
                end
                default: ;
            endcase
        end
    end

    assign secret_key = key_q;

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// tb/tb_rc4_phase_sequencer.sv - self-checking bench for rc4_phase_sequencer
module tb_rc4_phase_sequencer;

    localparam int KW = 24;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset_n, start, abort;
    logic [KW-1:0]   key_start, key_end;
    logic [2:0]      ph_start;
    logic [2:0]      ph_done = '0;
    logic [2:0]      ph_wren = '0;
    logic [3*AW-1:0] ph_addr = '0;
    logic [3*DW-1:0] ph_data = '0;
    logic            prga_ok = 1'b0;
    logic            reset_task, mem_wren;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data;
    logic [KW-1:0]   secret_key;
    logic            busy, found, exhausted, error;

    always #5 clk = ~clk;

    rc4_phase_sequencer #(
        .KEY_W(KW), .ADDR_W(AW), .DATA_W(DW), .KEY_STEP(1), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .key_start(key_start), .key_end(key_end),
        .ph_start(ph_start), .ph_done(ph_done), .ph_wren(ph_wren),
        .ph_addr(ph_addr), .ph_data(ph_data), .prga_ok(prga_ok),
        .reset_task(reset_task), .mem_wren(mem_wren), .mem_addr(mem_addr),
        .mem_data(mem_data), .secret_key(secret_key), .busy(busy),
        .found(found), .exhausted(exhausted), .error(error)
    );

    int checks = 0;
    int failures = 0;

    // stub engine controls
    int         lat[3] = '{1, 1, 1};
    logic [2:0] hang = '0;
    logic       has_tgt = 1'b0;
    logic [KW-1:0] tgt = '0;
    logic       force_done0 = 1'b0;
    int         scnt[3] = '{0, 0, 0};

    // Engine stubs: done arrives lat[p] cycles after the start pulse; the RAM
    // request lines carry fresh random values every cycle from all engines.
    always @(posedge clk) begin
        #1;
        ph_done = '0;
        for (int p = 0; p < 3; p++) begin
            if (reset_task) begin
                scnt[p] = 0;
            end else begin
                if (scnt[p] > 0) begin
                    scnt[p] = scnt[p] - 1;
                    if (scnt[p] == 0 && !hang[p]) ph_done[p] = 1'b1;
                end
                if (ph_start[p]) scnt[p] = lat[p];
            end
        end
        if (force_done0) ph_done[0] = 1'b1;
        prga_ok = has_tgt && (secret_key == tgt);
        ph_wren = 3'($urandom);
        ph_addr = 24'($urandom);
        ph_data = 24'($urandom);
    end

    typedef struct {
        logic [KW-1:0] ks, ke, tgt;
        logic          has_tgt;
        int            lat0, lat1, lat2;
        logic [2:0]    hang;
        logic [2:0]    exp_fl;   // {found, exhausted, error}
        logic [KW-1:0] exp_key;
        int            exp_clr;
    } vec_t;

    typedef struct {
        logic [2:0]    st;
        logic          rt;
        int            g;        // 3 = no grant
        logic          busy, f, x, e;
        logic [KW-1:0] key;
    } cyc_t;

    cyc_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic rt, input int g, input logic b,
                        input logic [2:0] fl, input logic [KW-1:0] k);
        cyc_t c;
        c.st = st; c.rt = rt; c.g = g; c.busy = b;
        c.f = fl[2]; c.x = fl[1]; c.e = fl[0]; c.key = k;
        exp_q.push_back(c);
    endtask

    // Expected cycle timeline from the cycle after start is sampled, built
    // from the phase durations: CLR, then GO + lat WAIT cycles per phase,
    // then NEXT_KEY, with a hung phase giving ERROR TIMEOUT cycles after GO.
    task automatic build(input vec_t v);
        logic [KW-1:0] key;
        logic [KW:0]   sum;
        logic [2:0]    term;
        bit            fin;
        int            l[3];
        l[0] = v.lat0; l[1] = v.lat1; l[2] = v.lat2;
        exp_q.delete();
        key = v.ks;
        fin = 0;
        term = 3'b000;
        while (!fin) begin
            push(3'b000, 1'b1, 3, 1'b1, 3'b000, key);
            for (int p = 0; p < 3 && !fin; p++) begin
                push(3'(1 << p), 1'b0, p, 1'b1, 3'b000, key);
                if (v.hang[p]) begin
                    repeat (TO - 1) push(3'b000, 1'b0, p, 1'b1, 3'b000, key);
                    term = 3'b001;
                    fin = 1;
                end else begin
                    repeat (l[p]) push(3'b000, 1'b0, p, 1'b1, 3'b000, key);
                end
            end
            if (!fin) begin
                if (v.has_tgt && key == v.tgt) begin
                    term = 3'b100;
                    fin = 1;
                end else begin
                    push(3'b000, 1'b0, 3, 1'b1, 3'b000, key);
                    if (key >= v.ke) begin
                        term = 3'b010;
                        fin = 1;
                    end else begin
                        sum = {1'b0, key} + 25'd1;
                        key = sum[KW] ? {KW{1'b1}} : sum[KW-1:0];
                    end
                end
            end
        end
        repeat (3) push(3'b000, 1'b0, 3, 1'b0, term, key);
    endtask

    task automatic chk_cycle(input int i, input cyc_t e);
        logic [48:0]   act, exp;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        w = 1'b0; a = '0; d = '0;
        if (e.g < 3) begin
            w = ph_wren[e.g];
            a = ph_addr[e.g*AW +: AW];
            d = ph_data[e.g*DW +: DW];
        end
        act = {ph_start, reset_task, busy, found, exhausted, error, secret_key, mem_wren, mem_addr, mem_data};
        exp = {e.st, e.rt, e.busy, e.f, e.x, e.e, e.key, w, a, d};
        chk($sformatf("cycle%0d", i), 64'(act), 64'(exp));
    endtask

    task automatic run_search(input vec_t v, input bit chk_final);
        int clr_seen;
        @(negedge clk);
        key_start = v.ks; key_end = v.ke;
        has_tgt = v.has_tgt; tgt = v.tgt;
        lat[0] = v.lat0; lat[1] = v.lat1; lat[2] = v.lat2;
        hang = v.hang;
        start = 1'b1;
        build(v);
        @(negedge clk);
        start = 1'b0;
        clr_seen = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            chk_cycle(i, exp_q[i]);
            if (reset_task) clr_seen++;
            @(negedge clk);
        end
        if (chk_final) begin
            chk("final_flags", 64'({found, exhausted, error}), 64'(v.exp_fl));
            chk("final_key", 64'(secret_key), 64'(v.exp_key));
            chk("clr_pulses", 64'(clr_seen), 64'(v.exp_clr));
        end
    endtask

    task automatic wait_phase(input int p, output bit ok);
        int n;
        n = 0;
        while (!ph_start[p] && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = ph_start[p];
        if (!ok) begin
            failures++;
            checks++;
            $display("FAIL wait_phase%0d timeout actual=0 expected=1", p);
        end
    endtask

    function automatic vec_t mk(input logic [KW-1:0] ks, ke, tg, input logic ht,
                                input int l0, l1, l2, input logic [2:0] hg,
                                input logic [2:0] fl, input logic [KW-1:0] k, input int nclr);
        vec_t v;
        v.ks = ks; v.ke = ke; v.tgt = tg; v.has_tgt = ht;
        v.lat0 = l0; v.lat1 = l1; v.lat2 = l2; v.hang = hg;
        v.exp_fl = fl; v.exp_key = k; v.exp_clr = nclr;
        return v;
    endfunction

    vec_t tbl[8];

    initial begin
        bit ok;
        int n;
        vec_t v;
        int len;
        logic [KW:0] sum;

        tbl[0] = mk(24'd0,      24'd5,      24'd3,  1, 10, 10, 10, 3'b000, 3'b100, 24'd3,      4);
        tbl[1] = mk(24'h3FFFFE, 24'h3FFFFF, 24'd0,  0, 10, 10, 10, 3'b000, 3'b010, 24'h3FFFFF, 2);
        tbl[2] = mk(24'd100,    24'd200,    24'd0,  0, 10, 10, 10, 3'b010, 3'b001, 24'd100,    1);
        tbl[3] = mk(24'd9,      24'd2,      24'd0,  0,  3,  4,  5, 3'b000, 3'b010, 24'd9,      1);
        tbl[4] = mk(24'd7,      24'd7,      24'd7,  1,  1,  1,  1, 3'b000, 3'b100, 24'd7,      1);
        tbl[5] = mk(24'd20,     24'd22,     24'd21, 1,  2, 15,  3, 3'b000, 3'b100, 24'd21,     2);
        tbl[6] = mk(24'hFFFFFE, 24'hFFFFFF, 24'd0,  0,  2,  2,  2, 3'b001, 3'b001, 24'hFFFFFE, 1);
        tbl[7] = mk(24'hFFFFFE, 24'hFFFFFF, 24'd0,  0,  2,  3,  2, 3'b000, 3'b010, 24'hFFFFFF, 2);

        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        key_start = '0; key_end = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({ph_start, reset_task, busy, found, exhausted, error,
                                  secret_key, mem_wren, mem_addr, mem_data}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", 64'({ph_start, reset_task, busy, found, exhausted, error,
                                 secret_key, mem_wren, mem_addr, mem_data}), 64'd0);

        for (int t = 0; t < 8; t++) run_search(tbl[t], 1);

        // spurious FILL done during KSA_WAIT, then abort inside PRGA_WAIT
        key_start = 24'h10; key_end = 24'h15; has_tgt = 1'b0;
        lat[0] = 10; lat[1] = 10; lat[2] = 10; hang = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_phase(1, ok);
        if (ok) begin
            n = 0;
            while (!ph_start[2] && n < 100) begin
                @(negedge clk);
                n++;
                force_done0 = (n == 3);
            end
            force_done0 = 1'b0;
            chk("ksa_to_prga_gap", 64'(n), 64'd11);
            repeat (3) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_cycle", 64'({busy, reset_task, ph_start, mem_wren, found, exhausted, error, secret_key}),
                64'({1'b0, 1'b1, 3'b000, 1'b0, 3'b000, 24'h10}));
            @(negedge clk);
            chk("after_abort", 64'({busy, reset_task}), 64'd0);
        end

        // asynchronous reset in the middle of KSA_WAIT
        key_start = 24'd4; key_end = 24'd9; lat[0] = 3; lat[1] = 10; lat[2] = 3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_phase(1, ok);
        repeat (2) @(negedge clk);
        chk("busy_before_reset", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({ph_start, reset_task, busy, found, exhausted, error,
                                        secret_key, mem_wren, mem_addr, mem_data}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        run_search(mk(24'd4, 24'd9, 24'd5, 1, 3, 3, 3, 3'b000, 3'b100, 24'd5, 2), 1);

        // randomized searches against the timeline model
        for (int r = 0; r < 10; r++) begin
            v.ks = ($urandom_range(0, 3) == 0) ? (24'hFFFFFF - 24'($urandom_range(0, 3))) : 24'($urandom);
            len = $urandom_range(0, 3);
            sum = {1'b0, v.ks} + 25'(len);
            v.ke = sum[KW] ? {KW{1'b1}} : sum[KW-1:0];
            if ($urandom_range(0, 4) == 0 && v.ks != 0) v.ke = v.ks - 24'd1;
            v.has_tgt = 1'($urandom_range(0, 1));
            v.tgt = v.ks + 24'($urandom_range(0, 3));
            v.lat0 = $urandom_range(1, 8);
            v.lat1 = $urandom_range(1, 8);
            v.lat2 = $urandom_range(1, 8);
            v.hang = ($urandom_range(0, 4) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
            v.exp_fl = '0; v.exp_key = '0; v.exp_clr = 0;
            run_search(v, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
